// File: rtl/dsp_arb_pkg.sv
// dsp_arb_pkg: shared widths, latency default, ID width helper and operand bundle for dsp_share_arb
package dsp_arb_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int A_W_DEF   = 30;
    localparam int B_W_DEF   = 18;
    localparam int C_W_DEF   = 48;
    localparam int P_W_DEF   = 48;
    localparam int LAT_DEF   = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [A_W_DEF-1:0] a;
        logic [B_W_DEF-1:0] b;
        logic [C_W_DEF-1:0] c;
    } operand_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr (mod N); with DSP_ARB_FIXED_PRIO_EN, index 0 wins outright and 1..N-1 rotate
module rr_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int N    = N_REQ_DEF,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt,
    output logic            any
);
    int idx;

    // scan from farthest to nearest offset so the nearest requesting index is the one that sticks
    always_comb begin
        gnt = ptr;
        any = |req;
        idx = 0;
`ifdef DSP_ARB_FIXED_PRIO_EN
        for (int k = N - 2; k >= 0; k--) begin
            idx = 1 + (int'(ptr) - int'(ptr != '0) + k) % (N - 1);
            if (req[idx]) gnt = ID_W'(idx);
        end
        if (req[0]) gnt = '0;
`else
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) gnt = ID_W'(idx);
        end
`endif
    end
endmodule

// File: rtl/dsp_share_arb.sv
// dsp_share_arb: shares one pipelined multiply-add slice among N_REQ requesters, tagging ops through LAT stages; DSP_ARB_FIXED_PRIO_EN gives requester 0 strict priority
module dsp_share_arb
    import dsp_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int C_W   = C_W_DEF,
    parameter int P_W   = P_W_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    input  logic [N_REQ*C_W-1:0] req_c,
    output logic [A_W-1:0]       dsp_a,
    output logic [B_W-1:0]       dsp_b,
    output logic [C_W-1:0]       dsp_c,
    output logic                 dsp_ce,
    output logic                 dsp_rst,
    input  logic [P_W-1:0]       dsp_p,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [P_W-1:0]       res_p
);
`ifdef DSP_ARB_FIXED_PRIO_EN
    localparam logic [ID_W-1:0] RST_PTR = ID_W'(1);
`else
    localparam logic [ID_W-1:0] RST_PTR = '0;
`endif

    logic [ID_W-1:0]           g, ptr_q, ptr_d;
    logic                      any, adv, dsp_rst_q, dsp_rst_d;
    logic [LAT-1:0]            vld_q, vld_d;
    logic [LAT-1:0][ID_W-1:0]  id_q, id_d;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (g),
        .any (any)
    );

    // outputs: the whole slice and tag pipe advance together, so a stalled result freezes everything
    always_comb begin
        res_valid = vld_q[LAT-1];
        res_id    = id_q[LAT-1];
        res_p     = dsp_p;
        dsp_rst   = dsp_rst_q;
        adv       = !dsp_rst_q && (!res_valid || res_ready);
        dsp_ce    = adv;
        req_ready = '0;
        req_ready[g] = adv && any;
        dsp_a     = req_a[g*A_W +: A_W];
        dsp_b     = req_b[g*B_W +: B_W];
        dsp_c     = req_c[g*C_W +: C_W];
    end

    // next state: bubbles shift like real ops so latency stays fixed at LAT
    always_comb begin
        dsp_rst_d = 1'b0;
        vld_d     = vld_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        if (adv) begin
            vld_d[0] = any;
            id_d[0]  = g;
            for (int k = 1; k < LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                id_d[k]  = id_q[k-1];
            end
`ifdef DSP_ARB_FIXED_PRIO_EN
            if (any && g != '0) ptr_d = (g == ID_W'(N_REQ - 1)) ? ID_W'(1) : g + 1'b1;
`else
            if (any) ptr_d = (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
`endif
        end
    end

    // state registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_rst_q <= 1'b1;
            vld_q     <= '0;
            id_q      <= '0;
            ptr_q     <= RST_PTR;
        end else begin
            dsp_rst_q <= dsp_rst_d;
            vld_q     <= vld_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
        end
    end
endmodule

// File: tb/tb_dsp_share_arb.sv
// tb_dsp_share_arb: directed bench for dsp_share_arb with a behavioural CE-gated multiply-add slice
module tb_dsp_share_arb;
    localparam int N   = 4;
    localparam int AW  = 30;
    localparam int BW  = 18;
    localparam int CW  = 48;
    localparam int PW  = 48;
    localparam int LAT = 4;
    localparam int IW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [N*CW-1:0] req_c;
    logic [AW-1:0]   dsp_a;
    logic [BW-1:0]   dsp_b;
    logic [CW-1:0]   dsp_c;
    logic            dsp_ce, dsp_rst;
    logic [PW-1:0]   dsp_p;
    logic            res_valid, res_ready;
    logic [IW-1:0]   res_id;
    logic [PW-1:0]   res_p;
    logic [PW-1:0]   p_pipe [LAT];
    int              total = 0;
    int              bad = 0;

    dsp_share_arb dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
        .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_p(res_p)
    );

    always #5 clk = ~clk;

    // behavioural slice: LAT register stages, all gated by CE, sync reset
    always @(posedge clk) begin
        if (dsp_rst) begin
            for (int k = 0; k < LAT; k++) p_pipe[k] <= '0;
        end else if (dsp_ce) begin
            p_pipe[0] <= PW'(dsp_a) * PW'(dsp_b) + PW'(dsp_c);
            for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
        end
    end
    assign dsp_p = p_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // requester i carries a=i+1, b=10, c=100*i
    function automatic logic [63:0] exp_p(input int i);
        return 64'((i + 1) * 10 + 100 * i);
    endfunction

    task automatic load_ops;
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(i + 1);
            req_b[i*BW +: BW] = BW'(10);
            req_c[i*CW +: CW] = CW'(100 * i);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        load_ops();
        repeat (3) tick();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ce", dsp_ce, 0);
        chk("rst_dsp_rst", dsp_rst, 1);
        rst_n = 1'b1;
        #1;
        chk("rel_dsp_rst_hold", dsp_rst, 1);
        chk("rel_req_ready", req_ready, 0);
        tick();
        chk("rel_dsp_rst_drop", dsp_rst, 0);
        chk("rel_ce", dsp_ce, 1);
        for (int k = 0; k < 8; k++) begin
            chk("rr_gnt", req_ready, 64'(4'b0001 << (k % 4)));
            if (k < 4) chk("rr_nores", res_valid, 0);
            else begin
                chk("rr_valid", res_valid, 1);
                chk("rr_id", res_id, 64'((k - 4) % 4));
                chk("rr_p", res_p, exp_p((k - 4) % 4));
            end
            tick();
        end
        req_valid = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", res_valid, 1);
            chk("drain_id", res_id, 64'(k));
            chk("drain_p", res_p, exp_p(k));
            tick();
        end
        chk("drain_empty", res_valid, 0);

        req_valid = 4'b1111;
        repeat (3) tick();
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        chk("bp_first_valid", res_valid, 1);
        chk("bp_first_id", res_id, 0);
        req_valid = 4'b0100;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ce", dsp_ce, 0);
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", res_valid, 1);
            chk("bp_id", res_id, 0);
            chk("bp_p", res_p, exp_p(0));
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        #1;
        chk("bp_rel_id0", res_id, 0);
        tick();
        chk("bp_rel_valid1", res_valid, 1);
        chk("bp_rel_id1", res_id, 1);
        chk("bp_rel_p1", res_p, exp_p(1));
        tick();
        chk("bp_rel_id2", res_id, 2);
        chk("bp_rel_p2", res_p, exp_p(2));
        tick();
        chk("bp_rel_empty", res_valid, 0);

        req_a[2*AW +: AW] = AW'(3);
        req_b[2*BW +: BW] = BW'(5);
        req_c[2*CW +: CW] = CW'(7);
        req_valid = 4'b0100;
        #1;
        chk("one_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            chk("one_wait", res_valid, 0);
            tick();
        end
        chk("one_valid", res_valid, 1);
        chk("one_id", res_id, 2);
        chk("one_p", res_p, 22);
        tick();
        chk("one_single", res_valid, 0);
        load_ops();

        req_valid = 4'b1111;
        repeat (3) tick();
        req_valid = '0;
        tick();
        chk("mid_pre_valid", res_valid, 1);
        chk("mid_pre_id", res_id, 3);
        chk("mid_pre_p", res_p, exp_p(3));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ce", dsp_ce, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("mid_no_stale", res_valid, 0);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        chk("mid_ptr_reset", req_ready, 4'b0001);

        req_valid = 4'b0011;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef DSP_ARB_FIXED_PRIO_EN
            chk("prio_gnt0", req_ready, 4'b0001);
`else
            chk("pair_rr", req_ready, (k % 2 == 0) ? 64'b0001 : 64'b0010);
`endif
            tick();
        end
        req_valid = 4'b0010;
        #1;
        chk("pair_only1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
